ps2_rx: RTL and testbench

PS/2 device-to-host receiver that feeds the keyboard controller's scancode path. It synchronises and de-glitches the raw `PS2_CLK`/`PS2_DAT` lines and deserialises 11-bit frames. For each good frame it emits one byte with a single-cycle `valid` strobe, which the keyboard controller consumes directly as `keyb_data`/`keyb_valid`. Malformed or stalled frames are dropped and reported on `err`. The block only receives; it never drives the bus.

---
 rtl/ps2_rx.sv | 170 +++++++++++++++++
 tb/tb_ps2_rx.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises and de-glitches the raw bus lines,
// deserialises 11-bit frames and strobes out each good scancode byte.
module ps2_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic       wb_clk,
  input  logic       nreset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       valid,
  output logic       err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Line 0 is the clock, line 1 is the data.
  logic [1:0] raw;
  logic [1:0] filt;

  assign raw = {ps2_dat, ps2_clk};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic          sync1_reg;
      logic          sync2_reg;
      logic          filt_reg;
      logic [FW-1:0] cnt_reg;

      always_ff @(posedge wb_clk) begin
        if (!nreset) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          filt_reg  <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg != filt_reg) begin
            // Level only flips once the disagreement has persisted FILTER samples.
            if (cnt_reg == FW'(FILTER)) begin
              filt_reg <= sync2_reg;
              cnt_reg  <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  state_t        state_reg, state_next;
  logic [7:0]    shreg_reg, shreg_next;
  logic [2:0]    idx_reg, idx_next;
  logic          acc_reg, acc_next;
  logic          par_ok_reg, par_ok_next;
  logic [7:0]    data_reg, data_next;
  logic          valid_reg, valid_next;
  logic          err_reg, err_next;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          clk_prev_reg;

  logic          fall;
  logic          bit_in;
  logic [TW-1:0] tcnt_inc;
  logic          timeout_hit;

  assign fall        = clk_prev_reg & ~filt[0];
  assign bit_in      = filt[1];
  assign tcnt_inc    = tcnt_reg + 1'b1;
  assign timeout_hit = (tcnt_inc == TW'(TIMEOUT - 1));

  always_ff @(posedge wb_clk) begin
    if (!nreset) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      idx_reg      <= '0;
      acc_reg      <= 1'b0;
      par_ok_reg   <= 1'b0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      err_reg      <= 1'b0;
      tcnt_reg     <= '0;
      clk_prev_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      shreg_reg    <= shreg_next;
      idx_reg      <= idx_next;
      acc_reg      <= acc_next;
      par_ok_reg   <= par_ok_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      err_reg      <= err_next;
      tcnt_reg     <= tcnt_next;
      clk_prev_reg <= filt[0];
    end
  end

  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    idx_next    = idx_reg;
    acc_next    = acc_reg;
    par_ok_next = par_ok_reg;
    data_next   = data_reg;
    valid_next  = 1'b0;
    err_next    = 1'b0;
    tcnt_next   = (fall || state_reg == IDLE) ? '0 : tcnt_inc;

    case (state_reg)
      IDLE: begin
        if (fall && !bit_in) begin
          state_next = DATA;
          idx_next   = '0;
          acc_next   = 1'b0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_next = {bit_in, shreg_reg[7:1]};
          acc_next   = acc_reg ^ bit_in;
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == 3'd7) begin
            state_next = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_ok_next = acc_reg ^ bit_in;
          state_next  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_next = IDLE;
          if (bit_in && par_ok_reg) begin
            data_next  = shreg_reg;
            valid_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // A fall in the same cycle wins; the frame is still alive.
    if (state_reg != IDLE && !fall && timeout_hit) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;
  assign err   = err_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: drives PS/2 frames on the raw pins and
// scoreboards the received bytes, error strobes and timing.
module tb_ps2_rx;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 1000;
  localparam int HALF    = 40;
  localparam int LAT     = 2 + FILTER + 1;

  logic       wb_clk  = 1'b0;
  logic       nreset  = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       err;
  logic       busy;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int drop_cyc = 0;
  int err_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  ps2_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk (wb_clk),
    .nreset (nreset),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .data   (data),
    .valid  (valid),
    .err    (err),
    .busy   (busy)
  );

  always #5 wb_clk = ~wb_clk;

  always @(posedge wb_clk) cyc <= cyc + 1;

  // Scoreboard monitor: every valid pops one expected byte.
  always @(negedge wb_clk) begin
    if (nreset) begin
      if (valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got data=%02h, expected no valid", data);
        end else begin
          exp_v = exp_q.pop_front();
          if (data !== exp_v) begin
            errors++;
            $display("FAIL valid_data: got %02h, expected %02h", data, exp_v);
          end else begin
            $display("frame ok: data=%02h", data);
          end
        end
        checks++;
        if (cyc - drop_cyc !== LAT + 1) begin
          errors++;
          $display("FAIL valid_latency: got %0d, expected %0d", cyc - drop_cyc, LAT + 1);
        end
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL strobe_overlap: err=%b with valid, expected 0", err);
        end
      end
      if (err) begin
        err_seen++;
        $display("err strobe at cycle %0d", cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [10:0] frame(input logic [7:0] d, input logic pflip, input logic stop);
    frame = {stop, (~^d) ^ pflip, d, 1'b0};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge wb_clk);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    ps2_dat = b;
    if (glitch) begin
      wait_cyc(2);
      ps2_clk = 1'b0;
      wait_cyc(5);
      ps2_clk = 1'b1;
      wait_cyc(HALF / 2 - 7);
    end else begin
      wait_cyc(HALF / 2);
    end
    ps2_clk  = 1'b0;
    drop_cyc = cyc;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(HALF / 2);
  endtask

  task automatic send_frame(input logic [10:0] f, input int glitch_at);
    for (int i = 0; i < 11; i++) send_bit(f[i], i == glitch_at);
    ps2_dat = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_reset;
    nreset = 1'b0;
    wait_cyc(4);
    checks++;
    if ({data, valid, err, busy} !== 11'h000) begin
      errors++;
      $display("FAIL reset_state: got data=%02h v=%b e=%b b=%b, expected 00 0 0 0", data, valid, err, busy);
    end
    nreset = 1'b1;
    wait_cyc(4);
  endtask

  task automatic test_good_frame;
    logic [10:0] f;
    int e0;
    f  = frame(8'h1C, 1'b0, 1'b1);
    e0 = err_seen;
    exp_q.push_back(8'h1C);
    for (int i = 0; i < 11; i++) begin
      send_bit(f[i], 1'b0);
      if (i == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_mid_frame: got %b, expected 1", busy);
        end
      end
    end
    ps2_dat = 1'b1;
    wait_cyc(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL good_missing_valid: %0d pending, expected 0", exp_q.size());
    end
    checks++;
    if (err_seen - e0 != 0) begin
      errors++;
      $display("FAIL good_err: got %0d err pulses, expected 0", err_seen - e0);
    end
    checks++;
    if (busy !== 1'b0 || data !== 8'h1C) begin
      errors++;
      $display("FAIL good_end: got busy=%b data=%02h, expected 0 1c", busy, data);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] seq [3];
    int e0;
    seq = '{8'hE0, 8'hF0, 8'h6B};
    e0  = err_seen;
    foreach (seq[i]) exp_q.push_back(seq[i]);
    foreach (seq[i]) begin
      for (int b = 0; b < 11; b++) send_bit(frame(seq[i], 1'b0, 1'b1) >> b, 1'b0);
    end
    ps2_dat = 1'b1;
    wait_cyc(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_missing_valid: %0d pending, expected 0", exp_q.size());
    end
    checks++;
    if (err_seen - e0 != 0) begin
      errors++;
      $display("FAIL b2b_err: got %0d err pulses, expected 0", err_seen - e0);
    end
  endtask

  task automatic test_bad_frames;
    int e0;
    e0 = err_seen;
    send_frame(frame(8'h1C, 1'b1, 1'b1), -1);
    checks++;
    if (err_seen - e0 != 1 || data !== 8'h6B || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_parity: got errs=%0d data=%02h busy=%b, expected 1 6b 0", err_seen - e0, data, busy);
    end
    e0 = err_seen;
    send_frame(frame(8'h33, 1'b0, 1'b0), -1);
    checks++;
    if (err_seen - e0 != 1 || data !== 8'h6B || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_stop: got errs=%0d data=%02h busy=%b, expected 1 6b 0", err_seen - e0, data, busy);
    end
  endtask

  task automatic test_timeout;
    logic [10:0] f;
    int e0;
    int first;
    f     = frame(8'hA5, 1'b0, 1'b1);
    e0    = err_seen;
    first = -1;
    for (int i = 0; i < 5; i++) send_bit(f[i], 1'b0);
    ps2_dat = f[5];
    wait_cyc(HALF / 2);
    ps2_clk  = 1'b0;
    drop_cyc = cyc;
    for (int c = 1; c <= LAT + TIMEOUT + 60; c++) begin
      @(negedge wb_clk);
      if (c == HALF) ps2_clk = 1'b1;
      if (err && first < 0) first = c;
    end
    ps2_dat = 1'b1;
    checks++;
    if (first != LAT + TIMEOUT) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d, expected %0d", first, LAT + TIMEOUT);
    end
    checks++;
    if (err_seen - e0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_end: got errs=%0d busy=%b, expected 1 0", err_seen - e0, busy);
    end
    exp_q.push_back(8'h5A);
    send_frame(frame(8'h5A, 1'b0, 1'b1), -1);
    checks++;
    if (exp_q.size() != 0 || data !== 8'h5A) begin
      errors++;
      $display("FAIL after_timeout: got pending=%0d data=%02h, expected 0 5a", exp_q.size(), data);
    end
  endtask

  task automatic test_glitch;
    int e0;
    e0 = err_seen;
    ps2_clk = 1'b0;
    wait_cyc(5);
    ps2_clk = 1'b1;
    wait_cyc(40);
    checks++;
    if (busy !== 1'b0 || err_seen - e0 != 0) begin
      errors++;
      $display("FAIL glitch_idle: got busy=%b errs=%0d, expected 0 0", busy, err_seen - e0);
    end
    exp_q.push_back(8'h2C);
    send_frame(frame(8'h2C, 1'b0, 1'b1), 4);
    checks++;
    if (exp_q.size() != 0 || data !== 8'h2C || err_seen - e0 != 0) begin
      errors++;
      $display("FAIL glitch_frame: got pending=%0d data=%02h errs=%0d, expected 0 2c 0", exp_q.size(), data, err_seen - e0);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [10:0] f;
    int e0;
    f  = frame(8'hF0, 1'b0, 1'b1);
    e0 = err_seen;
    for (int i = 0; i < 5; i++) send_bit(f[i], 1'b0);
    nreset = 1'b0;
    wait_cyc(1);
    nreset = 1'b1;
    for (int i = 5; i < 11; i++) send_bit(f[i], 1'b0);
    ps2_dat = 1'b1;
    wait_cyc(20);
    checks++;
    if (busy !== 1'b0 || data !== 8'h00 || err_seen - e0 != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b data=%02h errs=%0d pending=%0d, expected 0 00 0 0",
               busy, data, err_seen - e0, exp_q.size());
    end
    exp_q.push_back(8'h29);
    send_frame(frame(8'h29, 1'b0, 1'b1), -1);
    checks++;
    if (exp_q.size() != 0 || data !== 8'h29) begin
      errors++;
      $display("FAIL after_reset: got pending=%0d data=%02h, expected 0 29", exp_q.size(), data);
    end
  endtask

  initial begin
    @(negedge wb_clk);
    test_reset;
    test_good_frame;
    test_back_to_back;
    test_bad_frames;
    test_timeout;
    test_glitch;
    test_reset_mid_frame;
    wait_cyc(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
